// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed common-anode 4-digit seven-segment driver
module seg7_scan_driver #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] C1_in,
  input  logic [3:0] C2_in,
  input  logic [3:0] C3_in,
  input  logic [3:0] C4_in,
  input  logic [3:0] dp_mask,
  input  logic       lzb_en,
  output logic [3:0] AN,
  output logic [6:0] SEG,
  output logic       DP
);

  localparam int               CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_OFF  = 7'b1111111;

  // Slot timing state
  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic             slot_end;
  logic             frame_end;

  // Per-frame snapshot; snap_dig[0] holds C1 (leftmost)
  logic [3:0][3:0]  snap_dig;
  logic [3:0]       snap_dp;
  logic             snap_lzb;

  // Next-cycle pin values
  logic             in_dead;
  logic [3:0]       cur_dig;
  logic             lead_z1;
  logic             lead_z12;
  logic             lead_z123;
  logic             blank;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // BCD to active-low {g,f,e,d,c,b,a}; 10..14 blank, 15 is a minus sign
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      4'd15:   s = 7'b0111111;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);

  // Dead-time window at the start of every slot; absent entirely when DEAD_CYC is 0
  if (DEAD_CYC == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = (cnt < CNT_W'(DEAD_CYC));
  end

  // Slot counter and digit index: idx advances each time the slot counter wraps
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Capture all inputs together on the last cycle of a frame so a frame never tears
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_dig <= '0;
      snap_dp  <= 4'b0000;
      snap_lzb <= 1'b0;
    end else if (frame_end) begin
      snap_dig <= {C4_in, C3_in, C2_in, C1_in};
      snap_dp  <= dp_mask;
      snap_lzb <= lzb_en;
    end
  end

  // Decode the digit at the current position, applying leading-zero blanking
  always_comb begin
    cur_dig   = snap_dig[idx];
    lead_z1   = (snap_dig[0] == 4'd0);
    lead_z12  = lead_z1 && (snap_dig[1] == 4'd0);
    lead_z123 = lead_z12 && (snap_dig[2] == 4'd0);
    blank     = 1'b0;
    if (snap_lzb) begin
      case (idx)
        2'd0:    blank = lead_z1;
        2'd1:    blank = lead_z12;
        2'd2:    blank = lead_z123;
        default: blank = 1'b0;
      endcase
    end
    seg_next = blank ? SEG_OFF : seg_decode(cur_dig);
    dp_next  = ~snap_dp[2'd3 - idx];
    an_next  = in_dead ? 4'b1111 : ~(4'b1000 >> idx);
  end

  // Registered pin drivers; reset turns the display fully off at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AN  <= 4'b1111;
      SEG <= SEG_OFF;
      DP  <= 1'b1;
    end else begin
      AN  <= an_next;
      SEG <= seg_next;
      DP  <= dp_next;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver
module tb_seg7_scan_driver;

  localparam int SCAN_DIV = 8;
  localparam int DEAD_CYC = 2;
  localparam int FRAME    = 4 * SCAN_DIV;

  localparam logic [6:0] S_0   = 7'b1000000;
  localparam logic [6:0] S_1   = 7'b1111001;
  localparam logic [6:0] S_2   = 7'b0100100;
  localparam logic [6:0] S_3   = 7'b0110000;
  localparam logic [6:0] S_4   = 7'b0011001;
  localparam logic [6:0] S_5   = 7'b0010010;
  localparam logic [6:0] S_6   = 7'b0000010;
  localparam logic [6:0] S_7   = 7'b1111000;
  localparam logic [6:0] S_8   = 7'b0000000;
  localparam logic [6:0] S_9   = 7'b0010000;
  localparam logic [6:0] S_MIN = 7'b0111111;
  localparam logic [6:0] S_BLK = 7'b1111111;

  logic       CLK;
  logic       RST_N;
  logic [3:0] C1_in, C2_in, C3_in, C4_in;
  logic [3:0] dp_mask;
  logic       lzb_en;
  logic [3:0] AN;
  logic [6:0] SEG;
  logic       DP;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec;
  int   n_err;
  int   run;
  int   slot_n;
  bit   in_slot;
  logic [3:0] prev_an;

  seg7_scan_driver #(.SCAN_DIV(SCAN_DIV), .DEAD_CYC(DEAD_CYC)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .C1_in(C1_in), .C2_in(C2_in), .C3_in(C3_in), .C4_in(C4_in),
    .dp_mask(dp_mask), .lzb_en(lzb_en),
    .AN(AN), .SEG(SEG), .DP(DP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpm);
    exp_t e;
    e.an = 4'b0111; e.seg = s0; e.dp = ~dpm[3]; exp_q.push_back(e);
    e.an = 4'b1011; e.seg = s1; e.dp = ~dpm[2]; exp_q.push_back(e);
    e.an = 4'b1101; e.seg = s2; e.dp = ~dpm[1]; exp_q.push_back(e);
    e.an = 4'b1110; e.seg = s3; e.dp = ~dpm[0]; exp_q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                       input logic [3:0] c4, input logic [3:0] dpm, input logic lzb);
    C1_in = c1; C2_in = c2; C3_in = c3; C4_in = c4; dp_mask = dpm; lzb_en = lzb;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Monitor: each new anode-on slot pops one expectation; each slot's on-time is measured
  always @(negedge CLK) begin
    if (!RST_N) begin
      in_slot = 1'b0;
      run     = 0;
    end else if (AN != 4'b1111) begin
      if (!in_slot || AN != prev_an) begin
        if (in_slot)
          check($sformatf("slot%0d_len", slot_n), 16'(run), 16'(SCAN_DIV - DEAD_CYC));
        slot_n++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL slot%0d_unexpected: got AN=%b SEG=%b, expected no active slot", slot_n, AN, SEG);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("slot%0d_an", slot_n), 16'(AN), 16'(mon_e.an));
          check($sformatf("slot%0d_seg", slot_n), 16'(SEG), 16'(mon_e.seg));
          check($sformatf("slot%0d_dp", slot_n), 16'(DP), 16'(mon_e.dp));
        end
        in_slot = 1'b1;
        run     = 1;
        prev_an = AN;
      end else begin
        run++;
      end
    end else if (in_slot) begin
      check($sformatf("slot%0d_len", slot_n), 16'(run), 16'(SCAN_DIV - DEAD_CYC));
      in_slot = 1'b0;
    end
  end

  initial begin
    n_vec = 0; n_err = 0; run = 0; slot_n = 0; in_slot = 1'b0; prev_an = 4'b1111;
    RST_N = 1'b0;
    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b0);
    wait_cyc(3);
    check("reset_an", 16'(AN), 16'(4'b1111));
    check("reset_seg", 16'(SEG), 16'(S_BLK));
    check("reset_dp", 16'(DP), 16'(1'b1));

    // Frame 0: reset snapshot, all zeros with blanking off
    push_frame(S_0, S_0, S_0, S_0, 4'b0000);
    drive(4'd1, 4'd2, 4'd3, 4'd4, 4'b0000, 1'b0);
    @(negedge CLK);
    RST_N = 1'b1;
    push_frame(S_1, S_2, S_3, S_4, 4'b0000);
    wait_cyc(FRAME);

    // During frame 1 at idx 1, C3 moves to 7: visible only from frame 2
    wait_cyc(SCAN_DIV + 2);
    C3_in = 4'd7;
    push_frame(S_1, S_2, S_7, S_4, 4'b0000);
    wait_cyc(FRAME - SCAN_DIV - 2);

    drive(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    push_frame(S_BLK, S_BLK, S_BLK, S_0, 4'b0000);
    wait_cyc(FRAME);

    drive(4'd0, 4'd0, 4'd5, 4'd0, 4'b0000, 1'b1);
    push_frame(S_BLK, S_BLK, S_5, S_0, 4'b0000);
    wait_cyc(FRAME);

    drive(4'd15, 4'd10, 4'd9, 4'd8, 4'b0010, 1'b0);
    push_frame(S_MIN, S_BLK, S_9, S_8, 4'b0010);
    wait_cyc(FRAME);

    drive(4'd0, 4'd0, 4'd0, 4'd7, 4'b1000, 1'b1);
    push_frame(S_BLK, S_BLK, S_BLK, S_7, 4'b1000);
    wait_cyc(FRAME);

    drive(4'd0, 4'd5, 4'd6, 4'd0, 4'b0000, 1'b1);
    push_frame(S_BLK, S_5, S_6, S_0, 4'b0000);
    wait_cyc(FRAME);

    // Next frame repeats the same snapshot; reset hits it at idx 2, cnt 5
    begin
      exp_t e;
      e.an = 4'b0111; e.seg = S_BLK; e.dp = 1'b1; exp_q.push_back(e);
      e.an = 4'b1011; e.seg = S_5;   e.dp = 1'b1; exp_q.push_back(e);
      e.an = 4'b1101; e.seg = S_6;   e.dp = 1'b1; exp_q.push_back(e);
    end
    wait_cyc(FRAME);
    wait_cyc(2 * SCAN_DIV + 5);
    check("pre_reset_an", 16'(AN), 16'(4'b1101));
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_an", 16'(AN), 16'(4'b1111));
    check("async_rst_seg", 16'(SEG), 16'(S_BLK));
    check("async_rst_dp", 16'(DP), 16'(1'b1));
    check("async_rst_q", 16'(exp_q.size()), 16'd0);

    push_frame(S_0, S_0, S_0, S_0, 4'b0000);
    wait_cyc(2);
    RST_N = 1'b1;
    wait_cyc(2);
    check("post_rst_off", 16'(AN), 16'(4'b1111));
    wait_cyc(1);
    check("post_rst_first_an", 16'(AN), 16'(4'b0111));

    begin
      int k;
      for (k = 0; k < 200; k++) begin
        @(posedge CLK);
        if (exp_q.size() == 0 && !in_slot) break;
      end
      if (k == 200) begin
        n_vec++;
        n_err++;
        $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
